// File: rtl/voting_machine_pkg.sv
// -----------------------------------------------------------------------------
// voting_machine_pkg
// Shared constants and types for the four-candidate voting machine.
//   CNT_W        width of each candidate tally and of the LED bus
//   PRESS_CYCLES consecutive high cycles a button needs to count as one press
//   LED_HOLD     cycles the LEDs stay all-on after a recorded vote
//   NUM_CAND     number of candidates / buttons
// -----------------------------------------------------------------------------
package voting_machine_pkg;

  localparam int CNT_W        = 8;
  localparam int PRESS_CYCLES = 10;
  localparam int LED_HOLD     = 10;
  localparam int NUM_CAND     = 4;

  localparam int HOLD_W = $clog2(LED_HOLD + 1);

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/voting_machine_if.sv
// -----------------------------------------------------------------------------
// voting_machine_if
// Board-side signal bundle of the voting machine.
//   mode            0 = vote, 1 = result
//   button1..4      candidate buttons, active-high, synchronous to clk
//   led             confirmation flash or tally display
// Modports: master (board / bench side), slave (voting_machine side).
// -----------------------------------------------------------------------------
interface voting_machine_if;
  import voting_machine_pkg::*;

  logic mode;
  logic button1;
  logic button2;
  logic button3;
  logic button4;
  cnt_t led;

  modport master (
    output mode, button1, button2, button3, button4,
    input  led
  );

  modport slave (
    input  mode, button1, button2, button3, button4,
    output led
  );

endinterface

// File: rtl/voting_machine_button_control.sv
// -----------------------------------------------------------------------------
// button_control
// Qualifies one push-button: a press must stay high PRESS_LIMIT consecutive
// cycles, and produces a single-cycle valid_vote however long it is held.
//   clk         system clock
//   reset       asynchronous, active-low
//   button      raw button level, synchronous to clk
//   valid_vote  one-cycle pulse on the cycle the press counter reaches limit
// -----------------------------------------------------------------------------
module button_control
  import voting_machine_pkg::*;
#(
  parameter int PRESS_LIMIT = PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic valid_vote
);

  localparam int            W     = $clog2(PRESS_LIMIT + 1);
  localparam logic [W-1:0]  LIMIT = W'(PRESS_LIMIT);

  logic [W-1:0] press_cnt;
  // Cleared by reset and set once the button is seen low, so a button held
  // through reset has to be released before it can vote.
  logic         armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_cnt  <= '0;
      armed      <= 1'b0;
      valid_vote <= 1'b0;
    end else begin
      valid_vote <= 1'b0;
      if (!button) begin
        press_cnt <= '0;
        armed     <= 1'b1;
      end else if (armed && press_cnt != LIMIT) begin
        press_cnt  <= press_cnt + 1'b1;
        valid_vote <= (press_cnt == LIMIT - 1'b1);
      end
    end
  end

endmodule

// File: rtl/voting_machine.sv
// -----------------------------------------------------------------------------
// voting_machine
// Four-candidate voting machine. In vote mode a qualified press logs one vote
// and flashes the LEDs all-on; in result mode the LEDs show the tally of the
// lowest-numbered button currently held.
//   clk    system clock
//   reset  asynchronous, active-low
//   bus    voting_machine_if.slave (mode, button1..4 in; led out)
// Build option: define VOTING_MACHINE_SAT_EN to make tallies saturate at
// their maximum instead of wrapping.
// -----------------------------------------------------------------------------
module voting_machine
  import voting_machine_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  voting_machine_if.slave  bus
);

  logic [NUM_CAND-1:0] btn;
  logic [NUM_CAND-1:0] valid;
  logic                log_vote;
  cnt_t                tally [NUM_CAND];
  logic [HOLD_W-1:0]   hold;
  cnt_t                led_q;
  cnt_t                led_next;

  assign btn = {bus.button4, bus.button3, bus.button2, bus.button1};

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_btn
    button_control #(.PRESS_LIMIT(PRESS_CYCLES)) u_btn (
      .clk        (clk),
      .reset      (reset),
      .button     (btn[i]),
      .valid_vote (valid[i])
    );
  end

  function automatic cnt_t bump(input cnt_t c);
`ifdef VOTING_MACHINE_SAT_EN
    return (c == '1) ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction

  // Simultaneous qualified presses form an invalid ballot and are dropped.
  assign log_vote = $onehot(valid) && (bus.mode == MODE_VOTE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else if (log_vote) begin
      for (int i = 0; i < NUM_CAND; i++)
        if (valid[i]) tally[i] <= bump(tally[i]);
    end
  end

  // The flash still fires on a saturated tally since it tracks log_vote.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    hold <= '0;
    else if (bus.mode == MODE_RESULT) hold <= '0;
    else if (log_vote)             hold <= HOLD_W'(LED_HOLD);
    else if (hold != '0)           hold <= hold - 1'b1;
  end

  always_comb begin
    led_next = '0;
    if (bus.mode == MODE_VOTE) begin
      if (hold != '0) led_next = '1;
    end else begin
      if      (btn[0]) led_next = tally[0];
      else if (btn[1]) led_next = tally[1];
      else if (btn[2]) led_next = tally[2];
      else if (btn[3]) led_next = tally[3];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) led_q <= '0;
    else        led_q <= led_next;
  end

  assign bus.led = led_q;

endmodule

// File: tb/tb_voting_machine.sv
module tb_voting_machine;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tally [4];

  always #5 clk = ~clk;

  voting_machine_if vif ();

  voting_machine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks = n_checks + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input logic [3:0] m);
    vif.button1 = m[0];
    vif.button2 = m[1];
    vif.button3 = m[2];
    vif.button4 = m[3];
  endtask

  // Expected displayed tally from the number of votes cast.
  function automatic logic [7:0] exp_tally(input int n);
    int t;
    t = tally[n];
`ifdef VOTING_MACHINE_SAT_EN
    return (t > 255) ? 8'hFF : 8'(t);
`else
    return 8'(t % 256);
`endif
  endfunction

  task automatic read_tally(input int n);
    vif.mode = 1'b1;
    set_buttons(4'(1 << n));
    step();
    check($sformatf("tally%0d", n + 1), vif.led, exp_tally(n));
    set_buttons(4'b0000);
    vif.mode = 1'b0;
    step();
  endtask

  // One press episode: all buttons in mask rise together for len cycles.
  // A vote counts when exactly one button is pressed, long enough, in mode 0.
  // The flash is expected on cycles 12..21 after the rise (10 cycles to
  // qualify, one to log, one for the registered LED).
  task automatic episode(input logic [3:0] mask, input int len, input logic md, input string tag);
    bit   qual;
    int   low;
    int   total;
    logic [7:0] e;
    qual  = ($countones(mask) == 1) && (len >= 10) && (md == 1'b0);
    low   = 0;
    for (int i = 3; i >= 0; i--) if (mask[i]) low = i;
    total = ((len > 22) ? len : 22) + 2;
    vif.mode = md;
    set_buttons(mask);
    for (int k = 1; k <= total; k++) begin
      step();
      if (md == 1'b0) e = (qual && k >= 12 && k <= 21) ? 8'hFF : 8'h00;
      else            e = (k <= len && mask != 4'b0000) ? exp_tally(low) : 8'h00;
      check($sformatf("%s_k%0d", tag, k), vif.led, e);
      if (k == len) set_buttons(4'b0000);
    end
    if (qual) tally[low] = tally[low] + 1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_led_async", vif.led, 8'h00);
    repeat (3) step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) tally[i] = 0;
  endtask

  initial begin
    logic [3:0] m;
    int len;
    logic md;

    reset = 1'b0;
    vif.mode = 1'b0;
    set_buttons(4'b0000);
    for (int i = 0; i < 4; i++) tally[i] = 0;

    // Reset held for 10 cycles, then released with buttons idle.
    repeat (10) step();
    check("led_in_reset", vif.led, 8'h00);
    reset = 1'b1;
    step();
    check("led_after_reset", vif.led, 8'h00);
    for (int n = 0; n < 4; n++) read_tally(n);

    // One vote per long press, flash window, tally increments.
    episode(4'b0001, 20, 1'b0, "b1_vote1");
    read_tally(0);
    episode(4'b0001, 20, 1'b0, "b1_vote2");
    read_tally(0);

    // Short press produces nothing.
    episode(4'b0010, 5, 1'b0, "b2_short");
    read_tally(1);

    // Exactly PRESS_CYCLES is the minimum qualifying press.
    episode(4'b0100, 9, 1'b0, "b3_len9");
    episode(4'b0100, 10, 1'b0, "b3_len10");
    read_tally(2);

    // Simultaneous presses are an invalid ballot.
    episode(4'b0110, 20, 1'b0, "b23_dual");
    read_tally(1);
    read_tally(2);

    // Result mode: display only, priority to the lowest button.
    episode(4'b0100, 20, 1'b1, "b3_result");
    episode(4'b0101, 20, 1'b1, "b13_result");
    read_tally(2);

    // Randomized episodes against the model.
    for (int r = 0; r < 40; r++) begin
      m   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 25);
      md  = ($urandom_range(0, 3) == 0);
      episode(m, len, md, $sformatf("rnd%0d", r));
    end
    for (int n = 0; n < 4; n++) read_tally(n);

    // 256 votes for candidate 4: wrap (or saturate).
    do_reset();
    for (int v = 0; v < 256; v++) begin
      set_buttons(4'b1000);
      repeat (10) step();
      set_buttons(4'b0000);
      repeat (2) step();
      tally[3] = tally[3] + 1;
      if (v == 254) read_tally(3);
    end
    read_tally(3);

    // Reset mid-flash with the button still held through reset release.
    vif.mode = 1'b0;
    set_buttons(4'b0001);
    repeat (13) step();
    check("flash_before_reset", vif.led, 8'hFF);
    reset = 1'b0;
    #2;
    check("led_reset_midflash", vif.led, 8'h00);
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tally[i] = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("held_after_reset_k%0d", k), vif.led, 8'h00);
    end
    set_buttons(4'b0000);
    step();
    for (int n = 0; n < 4; n++) read_tally(n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/voting_machine.md
Name: voting_machine

Overview:
- Four-candidate electronic voting machine with one 8-bit vote counter per candidate.
- In vote mode (mode=0), a qualified press of buttonN adds one vote for candidate N, and the LEDs flash all-on as confirmation.
- In result mode (mode=1), the LEDs show the tally of the candidate whose button is held.
- Top-level block driven directly by board push-buttons and switches.

Parameters:
- PRESS_CYCLES, 10, consecutive clk cycles a button must be high for the press to qualify as a vote.
- LED_HOLD, 10, cycles the led output stays 8'hFF after a vote is recorded.
- CNT_W, 8, width of each candidate counter and of led.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = vote mode, 1 = result mode.
- button1  input  1  candidate 1 button, active-high; synchronous to clk.
- button2  input  1  candidate 2 button.
- button3  input  1  candidate 3 button.
- button4  input  1  candidate 4 button.
- led  output  CNT_W  confirmation flash or tally display.

Behaviour:
- Reset (reset=0, async): all four counters = 0, all press counters = 0, hold timer = 0, led = 8'h00. Takes effect mid-press or mid-flash; after release, a button still held must be released and pressed again to vote.
- Press qualification (per button):
  - Press counter increments each cycle the button is 1 and saturates at PRESS_CYCLES.
  - Counter clears on any cycle the button is 0.
  - valid_N pulses for exactly one cycle on the cycle the counter reaches PRESS_CYCLES.
  - Net effect: one vote per press, no matter how long the button is held. Presses shorter than PRESS_CYCLES produce nothing.
- Vote logging (mode=0 at the valid pulse cycle):
  - Exactly one valid_N high: counter N increments on that clock edge, and the hold timer loads LED_HOLD.
  - Two or more valid pulses in the same cycle: no counter changes; treated as an invalid ballot.
  - A valid pulse while mode=1: discarded, with no later replay.
- Counter arithmetic: CNT_W-bit unsigned; wraps 255->0 (see Optional Feature).
- LED output (registered, 1-cycle latency from inputs/counters):
  - mode=0: led = 8'hFF while the hold timer is nonzero, else 8'h00. The hold timer decrements each cycle it is nonzero.
  - mode=1: led = counter of the lowest-numbered button currently high (priority button1 > button2 > button3 > button4); 8'h00 if no button is high. The hold timer is cleared on entry to mode 1.
- Mode change mid-press: press counters are unaffected by mode; only the mode value at the valid-pulse cycle decides whether the vote counts.

Optional Feature:
- Macro VOTING_MACHINE_SAT_EN.
- Defined: candidate counters saturate at 2^CNT_W-1 (255); further qualified votes still trigger the LED flash but leave the count unchanged.
- Undefined: counters wrap modulo 2^CNT_W.

Decomposition:
- Package voting_machine_pkg holds:
  - CNT_W, PRESS_CYCLES and LED_HOLD defaults.
  - NUM_CAND=4.
  - MODE_VOTE=1'b0 and MODE_RESULT=1'b1 constants.
  - typedef for the count vector (logic [CNT_W-1:0]).
- Sub-module button_control (inputs clk, reset, button; output valid_vote), instantiated four times.
- Vote logger, hold timer and LED mux live in the top module.

Test Plan:
- Reset low 10 cycles, then high, all buttons 0 -> led=8'h00; mode=1 with each button pressed in turn -> led=0.
- mode=0, button1 high 20 cycles -> exactly one pulse; led=8'hFF for 10 cycles then 8'h00; mode=1 with button1 -> led=1. Repeat the press -> led=2.
- mode=0, button2 high 5 cycles then low -> no flash; mode=1 with button2 -> led=0.
- mode=0, button2 and button3 rise together for 20 cycles -> no flash; mode=1 shows 0 for both.
- mode=1, button3 held 20 cycles -> led shows tally only, no increment; button1 and button3 both held -> led = candidate 1 count.
- 256 votes for button4 -> wraps to 0 (255 with VOTING_MACHINE_SAT_EN). Reset asserted mid-flash -> led=8'h00 immediately and all counts 0.
